// File: rtl/uart_tx_fifo_feeder.sv
// rtl/uart_tx_fifo_feeder.sv - byte FIFO and start/busy sequencer feeding the UART transmitter
// Bytes are launched one per transmitter frame: start, wait for busy to rise, then wait for it to fall.
module uart_tx_fifo_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              flush,
  input  logic              tx_en,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic [15:0]       sent_count,
  output logic              tx_err
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TMO_LAST   = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        tcnt;
  logic              push;
  logic              launch;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign s_ready = !full && !flush;
  assign push    = s_valid && s_ready;
  assign launch  = (state == IDLE) && tx_en && !empty && !tx_busy;

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, launch})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A launch coinciding with flush still sends the head byte; the FIFO clears underneath it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      sent_count <= 16'h0000;
      tx_err     <= 1'b0;
      tcnt       <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            tx_start   <= 1'b1;
            tx_data    <= mem[rd_ptr];
            sent_count <= sent_count + 1'b1;
            tcnt       <= 8'h00;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tcnt == TMO_LAST) begin
            tx_err <= 1'b1;
            tcnt   <= 8'h00;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb/tb_uart_tx_fifo_feeder.sv - vector table, directed corner sequences and random traffic against a queue model
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 15;
  localparam int NV          = 26;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        flush = 1'b0;
  logic        tx_en = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic [15:0] sent_count;
  logic        tx_err;

  always #5 clk = ~clk;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .level(level), .empty(empty), .full(full), .sent_count(sent_count), .tx_err(tx_err)
  );

  typedef struct {
    int sv, sd, fl, en, bz;
    int lvl, st, d, sent;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  q[$];
  logic [7:0]  launched[$];
  int          sent_m = 0;
  logic [7:0]  last_data = 8'h00;
  logic        prev_start = 1'b0;
  int          stub_mode = 0;   // 0 bench-driven busy, 1 normal transmitter, 2 never acknowledges
  bit          pend = 1'b0;
  int          busy_cnt = 0;
  int          busy_len = 10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    launched.delete();
    sent_m = 0;
    last_data = 8'h00;
    prev_start = 1'b0;
    pend = 1'b0;
    busy_cnt = 0;
    tx_busy = 1'b0;
  endtask

  // One clock: inputs are already set at the falling edge; results are checked at the next falling edge.
  task automatic tick();
    logic       p_push, p_flush, p_en, p_busy;
    logic [7:0] p_data;
    #1;
    chk("s_ready", 32'(s_ready), 32'((q.size() < DEPTH) && !flush));
    p_push  = s_valid && (q.size() < DEPTH) && !flush;
    p_data  = s_data;
    p_flush = flush;
    p_en    = tx_en;
    p_busy  = tx_busy;
    @(posedge clk);
    @(negedge clk);
    if (tx_start) begin
      chk("launch_legal", 32'({prev_start, p_busy, p_en, q.size() > 0}), 32'(4'b0011));
      if (q.size() > 0) begin
        chk("tx_data", 32'(tx_data), 32'(q[0]));
        last_data = q[0];
        void'(q.pop_front());
      end
      launched.push_back(tx_data);
      sent_m++;
    end else begin
      chk("tx_data_hold", 32'(tx_data), 32'(last_data));
    end
    if (p_push) q.push_back(p_data);
    if (p_flush) q.delete();
    chk("level", 32'(level), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("sent_count", 32'(sent_count), 32'(16'(sent_m)));
    prev_start = tx_start;
    case (stub_mode)
      1: begin
        if (pend) begin
          tx_busy = 1'b1;
          busy_cnt = busy_len;
          pend = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) pend = 1'b1;
      end
      2: tx_busy = 1'b0;
      default: ;
    endcase
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = first + 8'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while ((q.size() > 0 || tx_busy || pend) && g < budget) begin
      tick();
      g++;
    end
    chk("drain_done", 32'(q.size() == 0 && !tx_busy), 32'(1));
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[NV];
    int   g, n;
    bit   acc;

    // sv  sd     fl en bz   lvl st d      sent
    tbl = '{
      '{1, 'hA5, 0, 0, 0,   1, 0, 'h00, 0},
      '{1, 'h3C, 0, 0, 0,   2, 0, 'h00, 0},
      '{0, 0,    0, 1, 1,   2, 0, 'h00, 0},
      '{0, 0,    0, 1, 0,   1, 1, 'hA5, 1},
      '{1, 'h77, 0, 1, 0,   2, 0, 'hA5, 1},
      '{0, 0,    0, 1, 1,   2, 0, 'hA5, 1},
      '{0, 0,    0, 1, 1,   2, 0, 'hA5, 1},
      '{0, 0,    0, 0, 0,   2, 0, 'hA5, 1},
      '{0, 0,    0, 0, 0,   2, 0, 'hA5, 1},
      '{0, 0,    0, 1, 0,   1, 1, 'h3C, 2},
      '{0, 0,    1, 1, 0,   0, 0, 'h3C, 2},
      '{1, 'h99, 0, 1, 1,   1, 0, 'h3C, 2},
      '{0, 0,    0, 1, 0,   1, 0, 'h3C, 2},
      '{0, 0,    0, 1, 0,   0, 1, 'h99, 3},
      '{0, 0,    0, 1, 1,   0, 0, 'h99, 3},
      '{0, 0,    0, 1, 0,   0, 0, 'h99, 3},
      '{1, 'h5A, 0, 1, 0,   1, 0, 'h99, 3},
      '{0, 0,    0, 1, 0,   0, 1, 'h5A, 4},
      '{0, 0,    0, 1, 1,   0, 0, 'h5A, 4},
      '{0, 0,    0, 1, 0,   0, 0, 'h5A, 4},
      '{1, 'h11, 0, 0, 0,   1, 0, 'h5A, 4},
      '{1, 'h22, 0, 0, 0,   2, 0, 'h5A, 4},
      '{0, 0,    1, 1, 0,   0, 1, 'h11, 5},
      '{0, 0,    0, 1, 1,   0, 0, 'h11, 5},
      '{0, 0,    0, 1, 0,   0, 0, 'h11, 5},
      '{0, 0,    0, 1, 0,   0, 0, 'h11, 5}
    };

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_sent", 32'(sent_count), 0);
    chk("rst_err", 32'(tx_err), 0);
    chk("rst_ready", 32'(s_ready), 1);
    rst = 1'b0;

    stub_mode = 0;
    for (int i = 0; i < NV; i++) begin
      s_valid = 1'(tbl[i].sv);
      s_data  = 8'(tbl[i].sd);
      flush   = 1'(tbl[i].fl);
      tx_en   = 1'(tbl[i].en);
      tx_busy = 1'(tbl[i].bz);
      tick();
      chk($sformatf("vec%0d_level", i), 32'(level), tbl[i].lvl);
      chk($sformatf("vec%0d_start", i), 32'(tx_start), tbl[i].st);
      chk($sformatf("vec%0d_data", i), 32'(tx_data), tbl[i].d);
      chk($sformatf("vec%0d_sent", i), 32'(sent_count), tbl[i].sent);
    end
    s_valid = 1'b0;
    flush = 1'b0;
    tx_busy = 1'b0;

    // Three back-to-back bytes through a transmitter busy for 10 cycles.
    stub_mode = 1;
    busy_len = 10;
    tx_en = 1'b1;
    launched.delete();
    push_bytes(8'h41, 3);
    drain(200);
    chk("tp1_count", launched.size(), 3);
    for (int i = 0; i < 3 && i < launched.size(); i++)
      chk($sformatf("tp1_byte%0d", i), 32'(launched[i]), 32'(8'h41 + 8'(i)));
    chk("tp1_sent", 32'(sent_count), 8);
    chk("tp1_level", 32'(level), 0);

    // Fill to DEPTH with transmission disabled; the 17th byte waits for space.
    tx_en = 1'b0;
    launched.delete();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      tick();
    end
    s_data = 8'h10;
    tick();
    chk("fill_level", 32'(level), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(s_ready), 0);
    tx_en = 1'b1;
    g = 0;
    while (s_valid && g < 100) begin
      acc = s_ready;
      tick();
      if (acc) s_valid = 1'b0;
      g++;
    end
    chk("fill_17th_taken", 32'(s_valid), 0);
    drain(600);
    chk("fill_count", launched.size(), 17);
    for (int i = 0; i < 17 && i < launched.size(); i++)
      chk($sformatf("fill_byte%0d", i), 32'(launched[i]), i);
    chk("fill_sent", 32'(sent_count), 25);

    // Push and launch in the same cycle at level 5.
    tx_en = 1'b0;
    push_bytes(8'hA0, 5);
    chk("same_pre", 32'(level), 5);
    tx_en = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    chk("same_start", 32'(tx_start), 1);
    chk("same_level", 32'(level), 5);
    drain(300);
    chk("same_sent", 32'(sent_count), 31);

    // Random mixed traffic; pointers wrap many times.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) busy_len = $urandom_range(1, 4);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 8'($urandom);
      tx_en   = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 59) == 0);
      tick();
    end
    s_valid = 1'b0;
    flush = 1'b0;
    tx_en = 1'b1;
    drain(2000);
    chk("rand_level", 32'(level), 0);
    chk("rand_err", 32'(tx_err), 0);

    // Flush while the first byte is in WAIT_DONE.
    busy_len = 10;
    tx_en = 1'b0;
    push_bytes(8'hC1, 4);
    launched.delete();
    tx_en = 1'b1;
    g = 0;
    while (!tx_busy && g < 20) begin tick(); g++; end
    chk("fl_busy_seen", 32'(tx_busy), 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (40) tick();
    chk("fl_launches", launched.size(), 1);
    chk("fl_data", 32'(tx_data), 32'(8'hC1));
    chk("fl_level", 32'(level), 0);
    chk("fl_err", 32'(tx_err), 0);

    // Transmitter that never acknowledges.
    stub_mode = 2;
    tx_en = 1'b0;
    push_bytes(8'hD1, 2);
    launched.delete();
    tx_en = 1'b1;
    g = 0;
    while (!tx_start && g < 10) begin tick(); g++; end
    chk("tmo_first_start", 32'(tx_start), 1);
    n = 0;
    while (!tx_err && n < 40) begin tick(); n++; end
    chk("tmo_cycles", n, ACK_TIMEOUT);
    n = 0;
    while (launched.size() < 2 && n < 10) begin tick(); n++; end
    chk("tmo_next_gap", n, 1);
    chk("tmo_next_data", 32'(tx_data), 32'(8'hD2));
    repeat (20) tick();
    chk("tmo_sticky", 32'(tx_err), 1);

    // Asynchronous reset during WAIT_DONE with three bytes buffered.
    stub_mode = 1;
    tx_en = 1'b0;
    push_bytes(8'hE1, 4);
    tx_en = 1'b1;
    g = 0;
    while (!tx_busy && g < 20) begin tick(); g++; end
    tick();
    chk("ar_level", 32'(level), 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_tx_start", 32'(tx_start), 0);
    chk("ar_tx_data", 32'(tx_data), 0);
    chk("ar_level0", 32'(level), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_sent", 32'(sent_count), 0);
    chk("ar_err", 32'(tx_err), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_bytes(8'h55, 1);
    g = 0;
    while (!tx_start && g < 10) begin tick(); g++; end
    chk("ar_post_start", 32'(tx_start), 1);
    chk("ar_post_data", 32'(tx_data), 32'(8'h55));
    chk("ar_post_sent", 32'(sent_count), 1);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte FIFO plus transmit sequencer between the BRAM readout path and the UART transmitter.
- Accepts bytes on a valid/ready stream and buffers up to DEPTH bytes.
- Hands bytes to the transmitter one at a time using its start/busy interface. It waits for busy to rise and then fall, so no byte is lost or duplicated.
- Counts bytes handed over and flags a transmitter that never acknowledges a start pulse.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 15, cycles allowed in WAIT_BUSY for tx_busy to rise; range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- s_valid  in  1  upstream byte valid
- s_data  in  8  upstream byte
- s_ready  out  1  FIFO can accept; combinational, equals !full && !flush
- flush  in  1  synchronous FIFO clear
- tx_en  in  1  permit new transmissions
- tx_start  out  1  single-cycle start pulse to transmitter, registered
- tx_data  out  8  byte to transmitter, registered; stable from the tx_start cycle until the next launch
- tx_busy  in  1  transmitter busy
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- sent_count  out  16  bytes launched since reset, wraps 0xFFFF->0
- tx_err  out  1  sticky; set on ACK_TIMEOUT expiry

Behaviour:
- Reset values:
  - tx_start=0, tx_data=0, level=0, empty=1, full=0, sent_count=0, tx_err=0.
  - Pointers = 0, FSM = IDLE, timeout counter = 0.
- Push: s_valid && s_ready at a clk edge writes s_data at the write pointer. Write pointer increments modulo DEPTH.
- Pop: occurs only on a FSM launch (see IDLE). Read pointer increments modulo DEPTH.
- Simultaneous push and pop: level unchanged, both pointers advance. Allowed only when not full.
- When full, a push is refused even if a pop happens in the same cycle.
- Flush:
  - Pointers and level go to 0 on the next edge; any push in that cycle is dropped.
  - Flush during WAIT_BUSY/WAIT_DONE does not abort the in-flight byte; tx_data is held.
  - Flush in the same cycle as an IDLE launch: the launch proceeds with the head byte, then the FIFO is cleared.
- IDLE state:
  - Launch condition: tx_en && !empty && !tx_busy.
  - On launch, next cycle: tx_start=1, tx_data=head byte, pop, sent_count+1, go to WAIT_BUSY, timeout counter cleared.
  - Otherwise tx_start=0.
- WAIT_BUSY state:
  - tx_start returns to 0 after exactly one cycle.
  - If tx_busy=1, go to WAIT_DONE.
  - Else the timeout counter increments. When it reaches ACK_TIMEOUT: set tx_err and return to IDLE. The byte counts as sent and is not retried.
- WAIT_DONE state: when tx_busy=0, go to IDLE. The earliest next launch is the cycle after IDLE is re-entered.
- Launch throughput: at most one launch per transmitter frame.
- tx_en deasserted mid-transfer: current byte completes normally, no new launch. Buffered bytes are retained.
- tx_busy already high in IDLE (external transmitter activity): no launch until it is low.
- Asynchronous reset mid-transfer: all state returns to reset values immediately and buffered bytes are discarded. tx_start is 0 from reset assertion.
- Latency: a byte pushed into an empty FIFO in IDLE with tx_en=1, tx_busy=0 at edge k produces tx_start=1 in the cycle after edge k+1.

Test Plan:
- Reset, tx_en=1, stub transmitter (busy rises 1 cycle after start, held 10 cycles). Push 0x41,0x42,0x43 back-to-back -> three tx_start pulses, each exactly one cycle, tx_data 0x41,0x42,0x43 in order, no pulse while busy=1, sent_count=3, final level=0.
- tx_en=0, push 17 bytes 0x00..0x10 with DEPTH=16 -> first 16 accepted, s_ready=0 on the 17th, full=1, level=16. Set tx_en=1 -> 0x00..0x0F transmitted in order; the 17th is accepted once s_ready reasserts.
- Push and launch in the same cycle at level=5 -> level stays 5; read and write pointers wrap correctly across 0 after 40 mixed ops; output byte order matches a reference queue.
- Push 4 bytes, assert flush during WAIT_DONE of byte 1 -> byte 1 completes on tx_data, level=0, no further tx_start, tx_err=0.
- Transmitter stub never raises busy, ACK_TIMEOUT=15 -> tx_err=1 exactly 15 cycles after WAIT_BUSY entry, FSM back in IDLE, next byte launches. tx_err stays 1 until rst.
- Assert rst while in WAIT_DONE with level=3 -> outputs at reset values immediately. After release, pushing 0x55 yields a tx_start with tx_data=0x55 and sent_count=1.
